// File: rtl/data_ram_banked_pkg.sv
// Shared constants for the banked MEM-stage data RAM.
package data_ram_banked_pkg;

    localparam int unsigned DataRamDataW = 32;
    localparam int unsigned DataRamDepth = 1024;
    localparam int unsigned DataRamAddrW = 32;

    localparam logic WriteEnable  = 1'b1;
    localparam logic WriteDisable = 1'b0;

    localparam logic [DataRamDataW-1:0] ZeroWord = '0;

endpackage

// File: rtl/data_ram_banked_if.sv
// Request/response channel of data_ram_banked; par_inj exists only with DATA_RAM_PARITY_EN.
interface data_ram_banked_if
    import data_ram_banked_pkg::*;
#(
    parameter int unsigned DATA_W = DataRamDataW,
    parameter int unsigned ADDR_W = DataRamAddrW
) ();
    localparam int unsigned NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [NB-1:0]     req_be;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;
`ifdef DATA_RAM_PARITY_EN
    logic              par_inj;
`endif

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
`ifdef DATA_RAM_PARITY_EN
        output par_inj,
`endif
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata, resp_ready,
`ifdef DATA_RAM_PARITY_EN
        input  par_inj,
`endif
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_ram_lane.sv
// One byte lane of the data RAM: DEPTH x 8 storage, sync write, registered read.
// Adds a 1-bit parity array when DATA_RAM_PARITY_EN is defined.
module data_ram_lane #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned IDX_W = 10
) (
    input  logic             clk,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] idx,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
`ifdef DATA_RAM_PARITY_EN
    ,
    input  logic             wpar,
    output logic             rpar
`endif
);
    logic [7:0] mem [DEPTH];

    // Storage is deliberately not reset; only the response path is.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
        if (re) begin
            rdata <= mem[idx];
        end
    end

`ifdef DATA_RAM_PARITY_EN
    logic par_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            par_mem[idx] <= wpar;
        end
        if (re) begin
            rpar <= par_mem[idx];
        end
    end
`endif
endmodule

// File: rtl/data_ram_banked.sv
// Parametrised single-port data RAM with valid/ready request and one-entry response register.
// Optional per-byte even parity enabled by defining DATA_RAM_PARITY_EN.
module data_ram_banked
    import data_ram_banked_pkg::*;
#(
    parameter int unsigned DATA_W = DataRamDataW,
    parameter int unsigned DEPTH  = DataRamDepth,
    parameter int unsigned ADDR_W = DataRamAddrW
) (
    input  logic              clk,
    input  logic              rst,
    data_ram_banked_if.slave  bus
);
    localparam int unsigned NB    = DATA_W / 8;
    localparam int unsigned OFF   = $clog2(NB);
    localparam int unsigned IDX_W = $clog2(DEPTH);

    logic              accept;
    logic              st_en;
    logic              ld_en;
    logic              range_err;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] lane_rdata;
    logic              par_err;
    logic              valid_q, valid_d;
    logic              range_q, range_d;

    // Address decode: pure bit slice, any upper bit set is a range error.
    assign idx       = bus.req_addr[IDX_W+OFF-1:OFF];
    assign range_err = |bus.req_addr[ADDR_W-1:IDX_W+OFF];

    if (OFF > 0) begin : g_off
        logic unused_off;
        assign unused_off = ^bus.req_addr[OFF-1:0];
    end

    assign bus.req_ready = ~valid_q | bus.resp_ready;
    assign accept        = bus.req_valid & bus.req_ready;
    assign st_en         = accept & (bus.req_we == WriteEnable) & ~range_err;
    assign ld_en         = accept & (bus.req_we == WriteDisable);

`ifdef DATA_RAM_PARITY_EN
    logic [NB-1:0] lane_rpar;
`endif

    for (genvar i = 0; i < NB; i++) begin : g_lane
        data_ram_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk   (clk),
            .we    (st_en & bus.req_be[i]),
            .re    (ld_en & ~range_err),
            .idx   (idx),
            .wdata (bus.req_wdata[8*i +: 8]),
            .rdata (lane_rdata[8*i +: 8])
`ifdef DATA_RAM_PARITY_EN
            ,
            .wpar  ((^bus.req_wdata[8*i +: 8]) ^ bus.par_inj),
            .rpar  (lane_rpar[i])
`endif
        );
    end

`ifdef DATA_RAM_PARITY_EN
    // Even parity: byte XOR stored parity must be zero on every lane.
    always_comb begin
        par_err = 1'b0;
        for (int i = 0; i < NB; i++) begin
            par_err = par_err | ((^lane_rdata[8*i +: 8]) ^ lane_rpar[i]);
        end
    end
`else
    assign par_err = 1'b0;
`endif

    // Response register: load fills, consumer drains, stall holds.
    always_comb begin
        valid_d = valid_q;
        range_d = range_q;
        if (ld_en) begin
            valid_d = 1'b1;
            range_d = range_err;
        end else if (bus.resp_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            range_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            range_q <= range_d;
        end
    end

    assign bus.resp_valid = valid_q;
    assign bus.resp_err   = valid_q & (range_q | par_err);
    assign bus.resp_rdata = (valid_q & ~range_q) ? lane_rdata : DATA_W'(ZeroWord);
endmodule

// File: tb/tb_data_ram_banked.sv
// Randomised scoreboard bench for data_ram_banked (parity checks when DATA_RAM_PARITY_EN is defined).
module tb_data_ram_banked;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned AW    = 32;

    typedef struct packed {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    data_ram_banked_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    data_ram_banked #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .ADDR_W (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   mon_en = 1'b0;
    bit   exp_valid = 1'b0;
    exp_t sb[$];
    logic [31:0] mdl_mem [DEPTH];
    logic [3:0]  mdl_bad [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the reference model follows the handshake rules directly.
    task automatic cycle(input bit v, input bit we, input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd, input bit rr, input bit pinj);
        bit          acc;
        bit          inr;
        int unsigned w;
        exp_t        x;
        @(negedge clk);
        bus.req_valid  = v;
        bus.req_we     = we;
        bus.req_addr   = addr;
        bus.req_be     = be;
        bus.req_wdata  = wd;
        bus.resp_ready = rr;
`ifdef DATA_RAM_PARITY_EN
        bus.par_inj    = pinj;
`endif
        #1;
        chk("resp_valid", 32'(bus.resp_valid), 32'(exp_valid));
        chk("req_ready", 32'(bus.req_ready), 32'(!exp_valid || rr));
        acc = v && (!exp_valid || rr);
        inr = addr < 32'(DEPTH * 4);
        w   = (addr / 4) % DEPTH;
        if (acc && we && inr) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) begin
                    mdl_mem[w][8*i +: 8] = wd[8*i +: 8];
                    mdl_bad[w][i] = pinj;
                end
            end
        end
        if (acc && !we) begin
            if (inr) begin
                x.d = mdl_mem[w];
`ifdef DATA_RAM_PARITY_EN
                x.e = |mdl_bad[w];
`else
                x.e = 1'b0;
`endif
            end else begin
                x.d = 32'h0;
                x.e = 1'b1;
            end
            sb.push_back(x);
        end
        if (acc && !we) exp_valid = 1'b1;
        else if (rr)    exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        repeat (2) @(posedge clk);
        sb.delete();
        exp_valid = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: compares every presented response against the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (mon_en) begin
                if (bus.resp_valid) begin
                    if (sb.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_resp: got rdata %h with no load outstanding", bus.resp_rdata);
                    end else begin
                        chk("resp_rdata", bus.resp_rdata, sb[0].d);
                        chk("resp_err", 32'(bus.resp_err), 32'(sb[0].e));
                        if (bus.resp_ready) void'(sb.pop_front());
                    end
                end else begin
                    chk("idle_rdata", bus.resp_rdata, 32'h0);
                    chk("idle_err", 32'(bus.resp_err), 32'h0);
                end
            end
        end
    end

    initial begin
        logic [31:0] a;
        int unsigned r;
        rst            = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_be     = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;
`ifdef DATA_RAM_PARITY_EN
        bus.par_inj    = 1'b0;
`endif
        do_reset();

        // Fill the working set so every later load sees defined bytes and parity.
        for (int w = 0; w < 32; w++) cycle(1, 1, 32'(w * 4), 4'hF, $urandom, 1, 0);
        cycle(1, 1, 32'hFFC, 4'hF, $urandom, 1, 0);

        cycle(1, 1, 32'h10, 4'hF, 32'hDEADBEEF, 1, 0);
        cycle(1, 0, 32'h10, 4'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
        cycle(1, 1, 32'h10, 4'b0101, 32'h11223344, 1, 0);
        cycle(1, 0, 32'h10, 4'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);

        // Back-pressure then back-to-back drain.
        cycle(1, 0, 32'h10, 4'h0, 32'h0, 1, 0);
        repeat (3) cycle(1, 0, 32'h14, 4'h0, 32'h0, 0, 0);
        cycle(1, 0, 32'h14, 4'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);

        // Out-of-range load and suppressed store.
        cycle(1, 0, 32'h1000, 4'h0, 32'h0, 1, 0);
        cycle(1, 1, 32'h1000, 4'hF, 32'h0, 1, 0);
        cycle(1, 0, 32'h0, 4'h0, 32'h0, 1, 0);
        cycle(1, 0, 32'hFFFF_FFFC, 4'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);

`ifdef DATA_RAM_PARITY_EN
        cycle(1, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 1, 1);
        cycle(1, 0, 32'h20, 4'h0, 32'h0, 1, 0);
        cycle(1, 1, 32'h20, 4'hF, 32'hA5A5A5A5, 1, 0);
        cycle(1, 0, 32'h20, 4'h0, 32'h0, 1, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
`endif

        for (int n = 0; n < 3000; n++) begin
            r = $urandom % 16;
            if (r == 0) begin
                case ($urandom % 3)
                    0:       a = 32'h1000;
                    1:       a = 32'hFFFF_FFFC;
                    default: a = $urandom | 32'h1000;
                endcase
            end else if (r == 1) begin
                a = 32'hFFC + ($urandom % 4);
            end else begin
                a = 32'(($urandom % 32) * 4 + ($urandom % 4));
            end
            cycle(($urandom % 4) != 0, ($urandom % 2) != 0, a, 4'($urandom), $urandom,
                  ($urandom % 4) != 0, ($urandom % 8) == 0);
        end

        // Reset while a response is held: it must be dropped.
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
        cycle(1, 0, 32'h10, 4'h0, 32'h0, 0, 0);
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 0, 0);
        do_reset();
        cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);

        repeat (3) cycle(0, 0, 32'h0, 4'h0, 32'h0, 1, 0);
        chk("sb_empty", 32'(sb.size()), 32'h0);
        @(negedge clk);
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
